// File: rtl/mvm_stream_host.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mvm_stream_host                                               |
// | Desc     : Host-side driver for a serial matrix-vector core. Buffers one |
// |            operand set (A row-major, then x), streams it on             |
// |            mvm_start/mvm_data and captures the N results that follow    |
// |            mvm_done into a readable result buffer.                      |
// |            Optional result checker: define MVM_HOST_CHECK_EN.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mvm_stream_host #(
    parameter int MAT_SCALE    = 4,
    parameter int INPUT_WIDTH  = 8,
    parameter int OUTPUT_WIDTH = 16
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              op_we,
    input  logic [$clog2(MAT_SCALE*MAT_SCALE+MAT_SCALE)-1:0]  op_addr,
    input  logic [INPUT_WIDTH-1:0]                            op_wdata,
    input  logic                                              go,
    output logic                                              busy,
    output logic                                              mvm_start,
    output logic [INPUT_WIDTH-1:0]                            mvm_data,
    input  logic                                              mvm_done,
    input  logic [OUTPUT_WIDTH-1:0]                           mvm_result,
    input  logic [$clog2(MAT_SCALE)-1:0]                      res_addr,
    output logic [OUTPUT_WIDTH-1:0]                           res_rdata,
    output logic                                              res_valid,
    output logic                                              mismatch
);

    // Elements per job and index widths (MAT_SCALE must be at least 2).
    localparam int C_NE = MAT_SCALE * MAT_SCALE + MAT_SCALE;
    localparam int AW   = $clog2(C_NE);
    localparam int RW   = $clog2(MAT_SCALE);
    localparam logic [AW-1:0] C_LAST = AW'(C_NE - 1);

    typedef enum logic [1:0] {
        SS_IDLE   = 2'd0,
        SS_START  = 2'd1,
        SS_STREAM = 2'd2
    } stream_state_t;

    typedef enum logic {
        CS_WAIT = 1'b0,
        CS_CAP  = 1'b1
    } cap_state_t;

    stream_state_t           r_sstate, w_snext;
    cap_state_t              r_cstate, w_cnext;
    logic [AW-1:0]           r_cnt;
    logic [RW-1:0]           r_ci;
    logic                    r_res_valid;
    logic                    w_last;
    logic                    w_cap_last;
    logic [INPUT_WIDTH-1:0]  r_buf [C_NE];
    logic [OUTPUT_WIDTH-1:0] r_res [MAT_SCALE];

    assign w_last     = (r_sstate == SS_STREAM) && (r_cnt == C_LAST);
    assign w_cap_last = (r_cstate == CS_CAP) && (r_ci == RW'(MAT_SCALE - 1));
    assign res_valid  = r_res_valid;
    assign res_rdata  = r_res[res_addr];

    // Operand buffer: host writes land only while no job is streaming.
    always_ff @(posedge clk) begin
        if (op_we && !busy && ({1'b0, op_addr} < (AW+1)'(C_NE)))
            r_buf[op_addr] <= op_wdata;
    end

    // Stream FSM state and element counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sstate <= SS_IDLE;
            r_cnt    <= '0;
        end else begin
            r_sstate <= w_snext;
            if ((r_sstate == SS_STREAM) && !w_last)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
        end
    end

    // Stream FSM next state and outputs; the last element can chain a new job.
    always_comb begin
        w_snext   = r_sstate;
        busy      = 1'b0;
        mvm_start = 1'b0;
        mvm_data  = '0;
        case (r_sstate)
            SS_IDLE: begin
                if (go)
                    w_snext = SS_START;
            end
            SS_START: begin
                busy      = 1'b1;
                mvm_start = 1'b1;
                w_snext   = SS_STREAM;
            end
            SS_STREAM: begin
                busy     = 1'b1;
                mvm_data = r_buf[r_cnt];
                if (w_last) begin
                    if (go)
                        mvm_start = 1'b1;
                    else
                        w_snext = SS_IDLE;
                end
            end
            default: w_snext = SS_IDLE;
        endcase
    end

    // Capture FSM state, result index and completion flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cstate    <= CS_WAIT;
            r_ci        <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_cstate <= w_cnext;
            if ((r_cstate == CS_WAIT) && mvm_done)
                r_res_valid <= 1'b0;
            if (w_cap_last)
                r_res_valid <= 1'b1;
            if ((r_cstate == CS_CAP) && !w_cap_last)
                r_ci <= r_ci + 1'b1;
            else
                r_ci <= '0;
        end
    end

    // Capture FSM next state; done pulses during capture are ignored.
    always_comb begin
        w_cnext = r_cstate;
        case (r_cstate)
            CS_WAIT: if (mvm_done)   w_cnext = CS_CAP;
            CS_CAP:  if (w_cap_last) w_cnext = CS_WAIT;
            default: w_cnext = CS_WAIT;
        endcase
    end

    // Result buffer: one result per capture cycle, abandoned on reset.
    always_ff @(posedge clk) begin
        if (!reset && (r_cstate == CS_CAP))
            r_res[r_ci] <= mvm_result;
    end

`ifdef MVM_HOST_CHECK_EN
    localparam int C_NN = MAT_SCALE * MAT_SCALE;
    localparam int C_PW = (2*INPUT_WIDTH > OUTPUT_WIDTH) ? 2*INPUT_WIDTH : OUTPUT_WIDTH;

    logic                    w_go_acc;
    logic                    r_snap;
    logic                    r_mac_run;
    logic [AW-1:0]           r_mi;
    logic [RW-1:0]           r_row;
    logic [RW-1:0]           r_col;
    logic [OUTPUT_WIDTH-1:0] r_acc;
    logic                    r_nxt_vld;
    logic                    r_exp_vld;
    logic                    r_mismatch;
    logic [INPUT_WIDTH-1:0]  r_cbuf [C_NE];
    logic [OUTPUT_WIDTH-1:0] r_nxt  [MAT_SCALE];
    logic [OUTPUT_WIDTH-1:0] r_exp  [MAT_SCALE];
    logic [AW-1:0]           w_xidx;
    logic [INPUT_WIDTH-1:0]  w_av;
    logic [INPUT_WIDTH-1:0]  w_xv;
    logic signed [C_PW-1:0]  w_a;
    logic signed [C_PW-1:0]  w_x;
    logic signed [C_PW-1:0]  w_p;
    logic [OUTPUT_WIDTH-1:0] w_sum;

    assign w_go_acc = go && ((r_sstate == SS_IDLE) || w_last);
    assign w_xidx   = AW'(C_NN) + AW'(r_col);
    assign w_av     = r_cbuf[r_mi];
    assign w_xv     = r_cbuf[w_xidx];
    assign w_a      = {{(C_PW-INPUT_WIDTH){w_av[INPUT_WIDTH-1]}}, w_av};
    assign w_x      = {{(C_PW-INPUT_WIDTH){w_xv[INPUT_WIDTH-1]}}, w_xv};
    assign w_p      = w_a * w_x;
    assign w_sum    = r_acc + w_p[OUTPUT_WIDTH-1:0];
    assign mismatch = r_mismatch;

    // Snapshot one cycle after acceptance so a same-cycle host write is included.
    always_ff @(posedge clk) begin
        if (r_snap)
            for (int i = 0; i < C_NE; i++)
                r_cbuf[i] <= r_buf[i];
    end

    // Sequential MAC into r_nxt, hand-over to r_exp once the pending job is captured,
    // and comparison of each captured result against r_exp.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_snap     <= 1'b0;
            r_mac_run  <= 1'b0;
            r_mi       <= '0;
            r_row      <= '0;
            r_col      <= '0;
            r_acc      <= '0;
            r_nxt_vld  <= 1'b0;
            r_exp_vld  <= 1'b0;
            r_mismatch <= 1'b0;
        end else begin
            r_snap <= w_go_acc;

            if (r_nxt_vld && (!r_exp_vld || w_cap_last)) begin
                for (int i = 0; i < MAT_SCALE; i++)
                    r_exp[i] <= r_nxt[i];
                r_exp_vld <= 1'b1;
                r_nxt_vld <= 1'b0;
            end else if (w_cap_last) begin
                r_exp_vld <= 1'b0;
            end

            if (r_snap) begin
                r_mac_run <= 1'b1;
                r_mi      <= '0;
                r_row     <= '0;
                r_col     <= '0;
                r_acc     <= '0;
            end else if (r_mac_run) begin
                r_mi <= r_mi + 1'b1;
                if (r_col == RW'(MAT_SCALE - 1)) begin
                    r_nxt[r_row] <= w_sum;
                    r_acc        <= '0;
                    r_col        <= '0;
                    r_row        <= r_row + 1'b1;
                    if (r_row == RW'(MAT_SCALE - 1)) begin
                        r_mac_run <= 1'b0;
                        r_nxt_vld <= 1'b1;
                    end
                end else begin
                    r_acc <= w_sum;
                    r_col <= r_col + 1'b1;
                end
            end

            if ((r_cstate == CS_CAP) && r_exp_vld && (mvm_result != r_exp[r_ci]))
                r_mismatch <= 1'b1;
        end
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule
`default_nettype wire
